// File: rtl/sevenseg_scan.sv
// sevenseg_scan: time-multiplexed hex driver for DIGITS seven-segment digits
// on a shared segment bus. New words are staged in a pending register and
// only promoted to the display register at a frame wrap, so a frame never
// shows a mix of old and new digits.

// Per-digit lane: hex decode plus leading-zero blank decision for one digit.
module sevenseg_digit #(
    parameter int LZ_BLANK = 1,
    parameter int IS_LSD   = 0
) (
    input  logic [3:0] nib,
    input  logic       dp_bit,
    input  logic       upper_zero,  // every nibble above this digit is zero
    output logic [6:0] seg_lit,     // active-high pattern, bit6=g .. bit0=a
    output logic       blank
);

    // Hex to segment pattern, active-high form.
    always_comb begin
        seg_lit = 7'h00;
        case (nib)
            4'h0: seg_lit = 7'h3F;
            4'h1: seg_lit = 7'h06;
            4'h2: seg_lit = 7'h5B;
            4'h3: seg_lit = 7'h4F;
            4'h4: seg_lit = 7'h66;
            4'h5: seg_lit = 7'h6D;
            4'h6: seg_lit = 7'h7D;
            4'h7: seg_lit = 7'h07;
            4'h8: seg_lit = 7'h7F;
            4'h9: seg_lit = 7'h6F;
            4'hA: seg_lit = 7'h77;
            4'hB: seg_lit = 7'h7C;
            4'hC: seg_lit = 7'h39;
            4'hD: seg_lit = 7'h5E;
            4'hE: seg_lit = 7'h79;
            4'hF: seg_lit = 7'h71;
            default: seg_lit = 7'h00;
        endcase
    end

    // The rightmost digit always shows; a lit decimal point keeps a digit on.
    assign blank = (LZ_BLANK != 0) && (IS_LSD == 0) && upper_zero &&
                   (nib == 4'h0) && !dp_bit;

endmodule

module sevenseg_scan #(
    parameter int DIGITS         = 4,
    parameter int CLK_DIV        = 50000,
    parameter int SEG_ACTIVE_LOW = 0,
    parameter int AN_ACTIVE_LOW  = 1,
    parameter int LZ_BLANK       = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   data,
    input  logic [DIGITS-1:0]     dp_in,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [DIGITS-1:0]     an,
    output logic                  frame_done
);

    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int CW = $clog2(CLK_DIV);

    // Idle (unlit / disabled) levels; XOR with these applies pin polarity.
    localparam logic [DIGITS-1:0] AN_OFF  = {DIGITS{AN_ACTIVE_LOW != 0}};
    localparam logic [6:0]        SEG_OFF = {7{SEG_ACTIVE_LOW != 0}};
    localparam logic              DP_OFF  = (SEG_ACTIVE_LOW != 0);

    typedef struct packed {
        logic [DIGITS-1:0][3:0] nib;
        logic [DIGITS-1:0]      dp;
    } frame_t;

    logic [CW-1:0] pre_q;
    logic [IW-1:0] idx_q;
    logic          tick;
    logic          last;
    logic          wrap;

    frame_t        pend_q;
    frame_t        disp_q;
    logic          pend_vld;

    logic [DIGITS:0]           uz;
    logic [DIGITS-1:0][6:0]    lane_seg;
    logic [DIGITS-1:0]         lane_blank;

    logic [6:0]        sel_seg;
    logic              sel_blank;
    logic              sel_dp;
    logic [DIGITS-1:0] sel_oh;

    logic [6:0]        seg_q;
    logic              dp_q;
    logic [DIGITS-1:0] an_q;

    assign tick       = (pre_q == CW'(CLK_DIV - 1));
    assign last       = (idx_q == IW'(DIGITS - 1));
    assign wrap       = tick && last;
    assign frame_done = wrap;

    // Prescaler: one tick every CLK_DIV clocks.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)       pre_q <= '0;
        else if (tick) pre_q <= '0;
        else           pre_q <= pre_q + 1'b1;
    end

    // Digit index advances on each tick and wraps after the leftmost digit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)       idx_q <= '0;
        else if (tick) idx_q <= last ? '0 : idx_q + 1'b1;
    end

    // Pending stage: latest load wins; a load on the wrap cycle stays pending.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_q   <= '0;
            pend_vld <= 1'b0;
        end else begin
            if (load) pend_q <= {data, dp_in};
            pend_vld <= load | (pend_vld & ~wrap);
        end
    end

    // Display register only changes at a frame wrap, so frames never tear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                   disp_q <= '0;
        else if (wrap && pend_vld) disp_q <= pend_q;
    end

    // uz[i]: nibbles i..DIGITS-1 of the display word are all zero.
    assign uz[DIGITS] = 1'b1;

    for (genvar i = 0; i < DIGITS; i++) begin : g_lane
        assign uz[i] = uz[i+1] && (disp_q.nib[i] == 4'h0);

        sevenseg_digit #(
            .LZ_BLANK (LZ_BLANK),
            .IS_LSD   ((i == 0) ? 1 : 0)
        ) u_digit (
            .nib        (disp_q.nib[i]),
            .dp_bit     (disp_q.dp[i]),
            .upper_zero (uz[i+1]),
            .seg_lit    (lane_seg[i]),
            .blank      (lane_blank[i])
        );
    end

    assign sel_seg   = lane_seg[idx_q];
    assign sel_blank = lane_blank[idx_q];
    assign sel_dp    = disp_q.dp[idx_q];
    assign sel_oh    = DIGITS'(1) << idx_q;

    // Registered pin drive: one clock behind the index, polarity applied here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an_q  <= AN_OFF;
            seg_q <= SEG_OFF;
            dp_q  <= DP_OFF;
        end else if (sel_blank) begin
            an_q  <= AN_OFF;
            seg_q <= SEG_OFF;
            dp_q  <= DP_OFF;
        end else begin
            an_q  <= sel_oh ^ AN_OFF;
            seg_q <= sel_seg ^ SEG_OFF;
            dp_q  <= sel_dp ^ DP_OFF;
        end
    end

    assign seg = seg_q;
    assign dp  = dp_q;
    assign an  = an_q;

endmodule
